vend_dispense_ctrl: RTL and testbench
=====================================

Name: vend_dispense_ctrl

Overview:
Controller that sequences the cola dispenser of the vending machine. It accumulates coin credit in half-yuan units and issues a motor request with a done handshake and timeout. After a vend it pays out change as paced pulses, and it supports cancel/refund. It sits between the coin acceptor pulses and the dispenser motor driver, replacing the fixed three-coin vend with a priced, handshaked vend.

Parameters:
PRICE, 5, vend price in half-yuan units (5 = 2.5 yuan); constraint 1 <= PRICE <= 2^CREDIT_W-4
CREDIT_W, 4, credit register width
TIMEOUT, 20, max DISPENSE cycles waiting for motor_done; >= 2
CHANGE_GAP, 4, cycles between change pulses; >= 2

Ports:
sys_clk  input  1  clock, rising edge
sys_rst_n  input  1  asynchronous active-low reset
pi_money_half  input  1  one-cycle pulse: 0.5 yuan inserted
pi_money_one  input  1  one-cycle pulse: 1 yuan inserted
pi_cancel  input  1  one-cycle pulse: user cancel request
motor_done  input  1  dispenser finished; level, sampled only in DISPENSE
po_motor_req  output  1  dispense request to motor driver
po_cola  output  1  one-cycle pulse: vend completed
po_change  output  1  one-cycle pulse per half-yuan returned
po_credit  output  CREDIT_W  current credit, half-yuan units
po_busy  output  1  coins/cancel currently ignored
po_fault  output  1  dispenser timeout occurred; sticky

Behaviour:
- Reset (async, any state): state=IDLE, credit=0; all outputs 0; all counters 0.
- All outputs are registered.
- States: IDLE (credit 0), ACCUM (0<credit<PRICE), DISPENSE, CHANGE, REFUND, FAULT.
- po_busy=1 in DISPENSE, CHANGE, REFUND and FAULT; 0 otherwise.
- Coin add (IDLE/ACCUM only):
  - credit_next = credit + (half?1:0) + (one?2:0); both pulses in one cycle add 3.
  - Coins in any other state are ignored.
  - PRICE constraint guarantees no overflow; max credit is PRICE+2.
- Vend threshold: at the edge where credit_next >= PRICE, state<=DISPENSE and po_motor_req<=1. The request is visible the cycle after the coin cycle.
- Cancel in ACCUM:
  - Coins in the same cycle are added first; then state<=CHANGE (refund without vend).
  - Cancel in IDLE is ignored.
  - If credit_next >= PRICE in the same cycle, the vend wins and cancel is ignored.
- DISPENSE:
  - po_motor_req held 1; timeout counter increments each cycle from 0.
  - motor_done=1 sampled: po_cola=1 for one cycle, po_motor_req<=0, credit<=credit-PRICE. Next state is CHANGE if remainder>0, else IDLE.
  - No done by the cycle the counter reaches TIMEOUT-1: po_motor_req<=0, state<=REFUND, credit unchanged.
  - done and timeout in the same cycle: done wins.
  - Cancel ignored.
- CHANGE / REFUND payout:
  - Gap counter cleared on entry. A po_change pulse fires when the counter = CHANGE_GAP-1; then the counter clears and credit decrements by 1.
  - First pulse comes CHANGE_GAP cycles after entry.
  - When credit reaches 0: CHANGE -> IDLE; REFUND -> FAULT.
- FAULT: po_fault=1, po_busy=1, all inputs ignored; exits only by reset.
- po_credit tracks the credit register at all times.
- Invariant: po_cola and po_change are never 1 in the same cycle.
- Invariant: po_motor_req=1 only in DISPENSE.

Test Plan:
- Exact vend: one, one, half on separate cycles -> po_credit 2,4,5. po_motor_req rises the next cycle. motor_done after 3 cycles -> single po_cola pulse, credit 0, IDLE, zero po_change.
- Overpay: one x3 -> credit 6, vend -> credit 1. Exactly one po_change, 4 cycles after entering CHANGE, then IDLE with po_busy=0.
- Simultaneous coins: half+one same cycle twice -> credit 3 then 6, vend, one change pulse. Coin pulses injected during DISPENSE/CHANGE leave credit unchanged.
- Cancel: one then cancel -> credit 2, no po_motor_req, two po_change pulses 4 cycles apart, then IDLE. Cancel in IDLE -> no effect.
- Timeout: reach 5, motor_done held 0 -> po_motor_req high exactly 20 cycles, then 5 po_change pulses. Then po_fault=1 permanently, coins ignored, until sys_rst_n pulse clears all.
- Async reset mid-DISPENSE and mid-CHANGE -> po_motor_req, po_change, po_credit drop to 0 immediately without a clock edge. After release, normal vend works.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: priced cola vend sequencer with coin credit, motor handshake/timeout,
// paced change/refund payout and a sticky fault state after a dispenser timeout.
module vend_dispense_ctrl #(
  parameter int PRICE      = 5,
  parameter int CREDIT_W   = 4,
  parameter int TIMEOUT    = 20,
  parameter int CHANGE_GAP = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_cancel,
  input  logic                motor_done,
  output logic                po_motor_req,
  output logic                po_cola,
  output logic                po_change,
  output logic [CREDIT_W-1:0] po_credit,
  output logic                po_busy,
  output logic                po_fault
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(CHANGE_GAP);
  typedef enum logic [2:0] {IDLE, ACCUM, DISPENSE, CHANGE, REFUND, FAULT} state_t;
  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q, coin_sum_d, remain_d;
  logic [TW-1:0]       tmo_q;
  logic [GW-1:0]       gap_q;
  logic                motor_req_q, cola_q, change_q, busy_q, fault_q;
  always_comb begin
    coin_sum_d = credit_q + CREDIT_W'(pi_money_half) + CREDIT_W'({pi_money_one, 1'b0});
    remain_d   = credit_q - CREDIT_W'(PRICE);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      motor_req_q <= 1'b0;
      cola_q      <= 1'b0;
      change_q    <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      cola_q   <= 1'b0;
      change_q <= 1'b0;
      case (state_q)
        IDLE, ACCUM: begin
          credit_q <= coin_sum_d;
          // reaching the price wins over a simultaneous cancel
          if (coin_sum_d >= CREDIT_W'(PRICE)) begin
            state_q     <= DISPENSE;
            motor_req_q <= 1'b1;
            busy_q      <= 1'b1;
            tmo_q       <= '0;
          end else if (state_q == ACCUM && pi_cancel) begin
            state_q <= CHANGE;
            busy_q  <= 1'b1;
            gap_q   <= '0;
          end else begin
            state_q <= (coin_sum_d == '0) ? IDLE : ACCUM;
          end
        end
        DISPENSE: begin
          if (motor_done) begin
            cola_q      <= 1'b1;
            motor_req_q <= 1'b0;
            credit_q    <= remain_d;
            state_q     <= (remain_d != '0) ? CHANGE : IDLE;
            busy_q      <= (remain_d != '0);
            gap_q       <= '0;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            motor_req_q <= 1'b0;
            state_q     <= REFUND;
            gap_q       <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        CHANGE, REFUND: begin
          if (gap_q == GW'(CHANGE_GAP - 1)) begin
            change_q <= 1'b1;
            gap_q    <= '0;
            credit_q <= credit_q - CREDIT_W'(1);
            if (credit_q == CREDIT_W'(1)) begin
              state_q <= (state_q == CHANGE) ? IDLE : FAULT;
              busy_q  <= (state_q != CHANGE);
              fault_q <= (state_q != CHANGE);
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end
  assign po_motor_req = motor_req_q;
  assign po_cola      = cola_q;
  assign po_change    = change_q;
  assign po_credit    = credit_q;
  assign po_busy      = busy_q;
  assign po_fault     = fault_q;
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: directed and randomized vend sessions; expectations come from a
// session-level model (running credit sum, remainder = credit - PRICE, pulses every CHANGE_GAP).
module tb_vend_dispense_ctrl;
  localparam int PRICE      = 5;
  localparam int CREDIT_W   = 4;
  localparam int TIMEOUT    = 20;
  localparam int CHANGE_GAP = 4;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic pi_money_half = 1'b0, pi_money_one = 1'b0, pi_cancel = 1'b0, motor_done = 1'b0;
  logic po_motor_req, po_cola, po_change, po_busy, po_fault;
  logic [CREDIT_W-1:0] po_credit;
  int checks = 0;
  int passes = 0;
  vend_dispense_ctrl #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .TIMEOUT(TIMEOUT), .CHANGE_GAP(CHANGE_GAP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_money_half(pi_money_half),
    .pi_money_one(pi_money_one), .pi_cancel(pi_cancel), .motor_done(motor_done),
    .po_motor_req(po_motor_req), .po_cola(po_cola), .po_change(po_change),
    .po_credit(po_credit), .po_busy(po_busy), .po_fault(po_fault)
  );
  always #5 sys_clk = ~sys_clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic coin(input int v, input bit c);
    pi_money_half = v[0];
    pi_money_one  = v[1];
    pi_cancel     = c;
    tick();
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
  endtask
  task automatic buy(input int v, input int m, output int nm);
    coin(v, 1'b0);
    nm = m + v;
    chk("buy_credit", 32'(po_credit), 32'(nm));
    chk("buy_motor_req", 32'(po_motor_req), 32'(nm >= PRICE));
    chk("buy_busy", 32'(po_busy), 32'(nm >= PRICE));
  endtask
  task automatic payout(input int n, input bit refund);
    for (int k = 1; k <= n; k++) begin
      for (int g = 0; g < CHANGE_GAP - 1; g++) begin
        pi_money_half = 1'($urandom);
        pi_money_one  = 1'($urandom);
        tick();
        chk("gap_change", 32'(po_change), 0);
        chk("gap_cola", 32'(po_cola), 0);
        chk("gap_credit", 32'(po_credit), 32'(n - k + 1));
        chk("gap_motor_req", 32'(po_motor_req), 0);
      end
      pi_money_half = 1'b0;
      pi_money_one  = 1'b0;
      tick();
      chk("pulse_change", 32'(po_change), 1);
      chk("pulse_credit", 32'(po_credit), 32'(n - k));
    end
    chk("payout_busy", 32'(po_busy), 32'(refund));
    chk("payout_fault", 32'(po_fault), 32'(refund));
  endtask
  task automatic dispense(input int d, input int total);
    for (int i = 0; i < d; i++) begin
      pi_money_half = 1'($urandom);
      pi_money_one  = 1'($urandom);
      pi_cancel     = 1'($urandom);
      tick();
      chk("disp_motor_req", 32'(po_motor_req), 1);
      chk("disp_credit", 32'(po_credit), 32'(total));
      chk("disp_busy", 32'(po_busy), 1);
    end
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    motor_done    = 1'b1;
    tick();
    motor_done = 1'b0;
    chk("vend_cola", 32'(po_cola), 1);
    chk("vend_motor_req", 32'(po_motor_req), 0);
    chk("vend_credit", 32'(po_credit), 32'(total - PRICE));
    chk("vend_busy", 32'(po_busy), 32'(total > PRICE));
    chk("vend_change", 32'(po_change), 0);
    payout(total - PRICE, 1'b0);
    if (total == PRICE) begin
      tick();
      chk("after_vend_cola", 32'(po_cola), 0);
    end
  endtask
  initial begin
    int m;
    int nm;
    int v;
    bit c;
    bit fin;
    tick();
    tick();
    chk("rst_credit", 32'(po_credit), 0);
    chk("rst_motor_req", 32'(po_motor_req), 0);
    chk("rst_busy", 32'(po_busy), 0);
    chk("rst_fault", 32'(po_fault), 0);
    chk("rst_cola_change", 32'({po_cola, po_change}), 0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick();
    m = 0;
    buy(2, m, m);
    buy(2, m, m);
    buy(1, m, m);
    dispense(3, m);
    m = 0;
    buy(2, m, m);
    buy(2, m, m);
    buy(2, m, m);
    dispense($urandom_range(0, TIMEOUT - 1), m);
    m = 0;
    buy(3, m, m);
    buy(3, m, m);
    dispense($urandom_range(0, TIMEOUT - 1), m);
    m = 0;
    buy(2, m, m);
    coin(0, 1'b1);
    chk("cancel_credit", 32'(po_credit), 2);
    chk("cancel_busy", 32'(po_busy), 1);
    chk("cancel_motor_req", 32'(po_motor_req), 0);
    payout(2, 1'b0);
    coin(0, 1'b1);
    chk("idle_cancel_busy", 32'(po_busy), 0);
    chk("idle_cancel_credit", 32'(po_credit), 0);
    coin(1, 1'b1);
    chk("idle_coin_cancel_busy", 32'(po_busy), 0);
    chk("idle_coin_cancel_credit", 32'(po_credit), 1);
    coin(0, 1'b1);
    payout(1, 1'b0);
    m = 0;
    buy(2, m, m);
    buy(2, m, m);
    coin(1, 1'b1);
    chk("vend_beats_cancel_req", 32'(po_motor_req), 1);
    dispense(TIMEOUT - 1, 5);
    m = 0;
    buy(2, m, m);
    buy(2, m, m);
    buy(1, m, m);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      chk("tmo_motor_req_high", 32'(po_motor_req), 1);
    end
    tick();
    chk("tmo_motor_req_low", 32'(po_motor_req), 0);
    chk("tmo_credit", 32'(po_credit), 5);
    chk("tmo_busy", 32'(po_busy), 1);
    chk("tmo_cola", 32'(po_cola), 0);
    payout(5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      pi_money_half = 1'($urandom);
      pi_money_one  = 1'($urandom);
      pi_cancel     = 1'($urandom);
      motor_done    = 1'($urandom);
      tick();
      chk("fault_sticky", 32'(po_fault), 1);
      chk("fault_busy", 32'(po_busy), 1);
      chk("fault_credit", 32'(po_credit), 0);
      chk("fault_motor_req", 32'(po_motor_req), 0);
    end
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    motor_done    = 1'b0;
    @(negedge sys_clk) sys_rst_n = 1'b0;
    #1;
    chk("fault_rst_fault", 32'(po_fault), 0);
    chk("fault_rst_busy", 32'(po_busy), 0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick();
    m = 0;
    buy(2, m, m);
    buy(2, m, m);
    buy(2, m, m);
    tick();
    tick();
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_disp_motor_req", 32'(po_motor_req), 0);
    chk("async_disp_credit", 32'(po_credit), 0);
    chk("async_disp_busy", 32'(po_busy), 0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick();
    m = 0;
    buy(2, m, m);
    buy(2, m, m);
    buy(3, m, m);
    motor_done = 1'b1;
    tick();
    motor_done = 1'b0;
    chk("async_chg_cola", 32'(po_cola), 1);
    for (int i = 0; i < CHANGE_GAP; i++) tick();
    chk("async_chg_pulse", 32'(po_change), 1);
    chk("async_chg_credit_pre", 32'(po_credit), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_chg_change", 32'(po_change), 0);
    chk("async_chg_credit", 32'(po_credit), 0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick();
    for (int s = 0; s < 25; s++) begin
      m = 0;
      fin = 1'b0;
      while (!fin) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("rnd_idle_credit", 32'(po_credit), 32'(m));
        end
        v = $urandom_range(0, 3);
        c = (m > 0) && ($urandom_range(0, 4) == 0);
        if (v == 0 && !c) v = 1;
        coin(v, c);
        nm = m + v;
        chk("rnd_credit", 32'(po_credit), 32'(nm));
        chk("rnd_motor_req", 32'(po_motor_req), 32'(nm >= PRICE));
        if (nm >= PRICE) begin
          dispense($urandom_range(0, TIMEOUT - 1), nm);
          fin = 1'b1;
        end else if (c) begin
          chk("rnd_cancel_busy", 32'(po_busy), 1);
          payout(nm, 1'b0);
          fin = 1'b1;
        end else begin
          chk("rnd_accum_busy", 32'(po_busy), 0);
          m = nm;
        end
      end
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
